// File: rtl/uart_core.sv
// Parametrised full-duplex UART: valid/ready transmitter, pulse-output receiver
// with input synchroniser, start-glitch rejection, parity/framing flags and break recovery.
module uart_core #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY != 0);
  localparam bit            ODD        = (PARITY == 2);

  generate
    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_core: illegal parameter combination");
    end
  endgenerate

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t              tx_state_reg;
  logic [CW-1:0]          tx_cnt_reg;
  logic [2:0]             tx_idx_reg;
  logic [DATA_BITS-1:0]   tx_shift_reg;
  logic                   tx_par_reg;
  logic                   tx_reg;
  logic                   tx_ready_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      tx_ready_reg <= 1'b1;
    end else if (tx_state_reg == TX_IDLE) begin
      tx_reg <= 1'b1;
      if (i_tx_valid && tx_ready_reg) begin
        tx_shift_reg <= i_tx_data;
        tx_par_reg   <= (^i_tx_data) ^ ODD;
        tx_reg       <= 1'b0;
        tx_cnt_reg   <= '0;
        tx_ready_reg <= 1'b0;
        tx_state_reg <= TX_START;
      end
    end else if (tx_cnt_reg != BIT_LAST) begin
      tx_cnt_reg <= tx_cnt_reg + 1'b1;
    end else begin
      tx_cnt_reg <= '0;
      case (tx_state_reg)
        TX_START: begin
          tx_reg       <= tx_shift_reg[0];
          tx_idx_reg   <= '0;
          tx_state_reg <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_idx_reg == DATA_LAST) begin
            tx_idx_reg <= '0;
            if (HAS_PARITY) begin
              tx_reg       <= tx_par_reg;
              tx_state_reg <= TX_PARITY;
            end else begin
              tx_reg       <= 1'b1;
              tx_state_reg <= TX_STOP;
            end
          end else begin
            tx_idx_reg   <= tx_idx_reg + 1'b1;
            tx_shift_reg <= tx_shift_reg >> 1;
            tx_reg       <= tx_shift_reg[1];
          end
        end
        TX_PARITY: begin
          tx_reg       <= 1'b1;
          tx_state_reg <= TX_STOP;
        end
        TX_STOP: begin
          if (tx_idx_reg == STOP_LAST) begin
            tx_ready_reg <= 1'b1;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_idx_reg <= tx_idx_reg + 1'b1;
          end
        end
        default: begin
          tx_reg       <= 1'b1;
          tx_ready_reg <= 1'b1;
          tx_state_reg <= TX_IDLE;
        end
      endcase
    end
  end

  assign o_tx       = tx_reg;
  assign o_tx_ready = tx_ready_reg;

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [1:0]             sync_reg;
  logic                   rx_s;
  rx_state_t              rx_state_reg;
  logic [CW-1:0]          rx_cnt_reg;
  logic [2:0]             rx_idx_reg;
  logic [DATA_BITS-1:0]   rx_shift_reg;
  logic                   rx_perr_pend_reg;
  logic [DATA_BITS-1:0]   rx_data_reg;
  logic                   rx_valid_reg;
  logic                   rx_perr_reg;
  logic                   rx_ferr_reg;
  logic                   rx_busy_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], i_rx};
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state_reg     <= RX_IDLE;
      rx_cnt_reg       <= '0;
      rx_idx_reg       <= '0;
      rx_shift_reg     <= '0;
      rx_perr_pend_reg <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_perr_reg      <= 1'b0;
      rx_ferr_reg      <= 1'b0;
      rx_busy_reg      <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_cnt_reg   <= '0;
            rx_busy_reg  <= 1'b1;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_reg != HALF_LAST) begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end else begin
            rx_cnt_reg <= '0;
            if (rx_s) begin
              rx_busy_reg  <= 1'b0;
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_idx_reg   <= '0;
              rx_state_reg <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg != BIT_LAST) begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end else begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_s, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_idx_reg == DATA_LAST) begin
              rx_perr_pend_reg <= 1'b0;
              rx_state_reg     <= HAS_PARITY ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx_reg <= rx_idx_reg + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_cnt_reg != BIT_LAST) begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end else begin
            rx_cnt_reg       <= '0;
            rx_perr_pend_reg <= rx_s ^ (^rx_shift_reg) ^ ODD;
            rx_state_reg     <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg != BIT_LAST) begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end else begin
            // Returning to IDLE at mid-stop rearms for a start edge with minimum spacing.
            rx_cnt_reg   <= '0;
            rx_data_reg  <= rx_shift_reg;
            rx_valid_reg <= 1'b1;
            rx_perr_reg  <= rx_perr_pend_reg;
            rx_ferr_reg  <= !rx_s;
            if (rx_s) begin
              rx_busy_reg  <= 1'b0;
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_state_reg <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) begin
            rx_busy_reg  <= 1'b0;
            rx_state_reg <= RX_IDLE;
          end
        end
        default: begin
          rx_busy_reg  <= 1'b0;
          rx_state_reg <= RX_IDLE;
        end
      endcase
    end
  end

  assign o_rx_data       = rx_data_reg;
  assign o_rx_valid      = rx_valid_reg;
  assign o_rx_parity_err = rx_perr_reg;
  assign o_rx_frame_err  = rx_ferr_reg;
  assign o_rx_busy       = rx_busy_reg;

endmodule

// File: tb/tb_uart_core.sv
// Randomised self-checking bench for uart_core: three instances (8N1, 8E1, 7O2)
// checked against a bit-list frame model with loopback and bench-driven RX lines.
`timescale 1ns/1ps
module tb_uart_core;

  localparam int CPB = 16;
  int DB[3]  = '{8, 8, 7};
  int PAR[3] = '{0, 1, 2};
  int SB[3]  = '{1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  logic [2:0] tx_valid_r = '0;
  logic [7:0] tx_data_r [3];
  logic [2:0] loop = '0;
  logic [2:0] rx_drv = '1;
  logic [2:0] tx_w, tx_ready_w, rx_valid_w, rx_pe_w, rx_fe_w, rx_busy_w;
  logic [7:0] rx_data_w [3];
  logic [6:0] rx_data7;
  wire  [2:0] rx_in = (loop & tx_w) | (~loop & rx_drv);

  assign rx_data_w[2] = {1'b0, rx_data7};

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rx_ev_t;
  rx_ev_t rxlog[$];
  int     busy_cnt[3] = '{0, 0, 0};
  bit     frame_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data_r[0]), .i_tx_valid(tx_valid_r[0]),
    .o_tx_ready(tx_ready_w[0]), .o_tx(tx_w[0]), .i_rx(rx_in[0]), .o_rx_data(rx_data_w[0]),
    .o_rx_valid(rx_valid_w[0]), .o_rx_parity_err(rx_pe_w[0]), .o_rx_frame_err(rx_fe_w[0]),
    .o_rx_busy(rx_busy_w[0]));

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data_r[1]), .i_tx_valid(tx_valid_r[1]),
    .o_tx_ready(tx_ready_w[1]), .o_tx(tx_w[1]), .i_rx(rx_in[1]), .o_rx_data(rx_data_w[1]),
    .o_rx_valid(rx_valid_w[1]), .o_rx_parity_err(rx_pe_w[1]), .o_rx_frame_err(rx_fe_w[1]),
    .o_rx_busy(rx_busy_w[1]));

  uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data_r[2][6:0]), .i_tx_valid(tx_valid_r[2]),
    .o_tx_ready(tx_ready_w[2]), .o_tx(tx_w[2]), .i_rx(rx_in[2]), .o_rx_data(rx_data7),
    .o_rx_valid(rx_valid_w[2]), .o_rx_parity_err(rx_pe_w[2]), .o_rx_frame_err(rx_fe_w[2]),
    .o_rx_busy(rx_busy_w[2]));

  // Event recorder: every received frame is logged with its cycle stamp.
  always @(negedge clk) begin
    rx_ev_t e;
    for (int i = 0; i < 3; i++) begin
      if (rx_valid_w[i] === 1'b1) begin
        e.idx = i; e.d = rx_data_w[i]; e.pe = rx_pe_w[i]; e.fe = rx_fe_w[i]; e.cyc = cyc;
        rxlog.push_back(e);
      end
      if (rx_busy_w[i] === 1'b1) busy_cnt[i]++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Frame model: start bit, data LSB first, optional parity, stop bit(s).
  function automatic void build_frame(input int i, input logic [7:0] d, input bit flip_par,
                                      input bit stop_val);
    bit p;
    frame_q.delete();
    frame_q.push_back(1'b0);
    p = 1'b0;
    for (int b = 0; b < DB[i]; b++) begin
      frame_q.push_back(d[b]);
      p = p ^ d[b];
    end
    if (PAR[i] != 0) begin
      if (PAR[i] == 2) p = ~p;
      frame_q.push_back(p ^ flip_par);
    end
    frame_q.push_back(stop_val);
    for (int s = 1; s < SB[i]; s++) frame_q.push_back(1'b1);
  endfunction

  function automatic int frame_cycles(input int i);
    return (1 + DB[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i]) * CPB;
  endfunction

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (tx_ready_w[i] !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready_w[i] !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready dut%0d: tx_ready=%b, required 1 within 5000 cycles", i, tx_ready_w[i]);
    end
  endtask

  task automatic tx_frame(input int i, input logic [7:0] d);
    int bad, first_c;
    loop[i] = 1'b1;
    wait_ready(i);
    build_frame(i, d, 1'b0, 1'b1);
    tx_data_r[i] = d;
    tx_valid_r[i] = 1'b1;
    @(negedge clk);
    tx_valid_r[i] = 1'b0;
    tx_data_r[i] = ~d;
    checks++;
    if (tx_ready_w[i] !== 1'b0) begin
      errors++;
      $display("FAIL tx_ready_drop dut%0d: got %b, required 0 after accept", i, tx_ready_w[i]);
    end
    bad = 0; first_c = -1;
    for (int c = 0; c < frame_q.size() * CPB; c++) begin
      if (c > 0) @(negedge clk);
      if (tx_w[i] !== frame_q[c / CPB]) begin
        if (bad == 0) first_c = c;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tx_wave dut%0d data=%02h: %0d wrong cycles, first at cycle %0d (bit %0d), required bit %0b",
               i, d, bad, first_c, first_c / CPB, frame_q[first_c / CPB]);
    end
    @(negedge clk);
    checks++;
    if (tx_ready_w[i] !== 1'b1 || tx_w[i] !== 1'b1) begin
      errors++;
      $display("FAIL tx_return dut%0d: ready=%b tx=%b %0d cycles after accept, required 1/1",
               i, tx_ready_w[i], tx_w[i], frame_cycles(i));
    end
  endtask

  task automatic drive_frame(input int i, input logic [7:0] d, input bit flip_par,
                             input bit stop_val, output int start_cyc);
    loop[i] = 1'b0;
    build_frame(i, d, flip_par, stop_val);
    start_cyc = cyc;
    for (int b = 0; b < frame_q.size(); b++) begin
      rx_drv[i] = frame_q[b];
      repeat (CPB) @(negedge clk);
    end
    if (stop_val) rx_drv[i] = 1'b1;
  endtask

  task automatic expect_rx(input int i, input logic [7:0] d, input logic pe, input logic fe,
                           input string nm, output int ev_cyc);
    int n;
    logic [7:0] m;
    m = 8'((1 << DB[i]) - 1);
    n = 0;
    ev_cyc = -1;
    while (rxlog.size() == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (rxlog.size() != 1) begin
      errors++;
      $display("FAIL %s_count dut%0d: %0d frames received, required 1", nm, i, rxlog.size());
    end
    if (rxlog.size() > 0) begin
      checks++;
      if (rxlog[0].idx != i) begin
        errors++;
        $display("FAIL %s_source: frame from dut%0d, required dut%0d", nm, rxlog[0].idx, i);
      end
      checks++;
      if (rxlog[0].d !== (d & m)) begin
        errors++;
        $display("FAIL %s_data dut%0d: got %02h, required %02h", nm, i, rxlog[0].d, d & m);
      end
      checks++;
      if (rxlog[0].pe !== pe) begin
        errors++;
        $display("FAIL %s_parity_err dut%0d: got %b, required %b", nm, i, rxlog[0].pe, pe);
      end
      checks++;
      if (rxlog[0].fe !== fe) begin
        errors++;
        $display("FAIL %s_frame_err dut%0d: got %b, required %b", nm, i, rxlog[0].fe, fe);
      end
      ev_cyc = rxlog[0].cyc;
    end
    rxlog.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_valid_r = '1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_w[i] !== 1'b1) begin errors++; $display("FAIL reset_tx dut%0d: got %b, required 1", i, tx_w[i]); end
      checks++;
      if (tx_ready_w[i] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d: got %b, required 1", i, tx_ready_w[i]); end
      checks++;
      if (rx_data_w[i] !== 8'h00) begin errors++; $display("FAIL reset_rx_data dut%0d: got %02h, required 00", i, rx_data_w[i]); end
      checks++;
      if (rx_valid_w[i] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid dut%0d: got %b, required 0", i, rx_valid_w[i]); end
      checks++;
      if (rx_pe_w[i] !== 1'b0 || rx_fe_w[i] !== 1'b0) begin
        errors++; $display("FAIL reset_flags dut%0d: pe=%b fe=%b, required 0/0", i, rx_pe_w[i], rx_fe_w[i]);
      end
      checks++;
      if (rx_busy_w[i] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b, required 0", i, rx_busy_w[i]); end
    end
    tx_valid_r = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rxlog.delete();
  endtask

  task automatic test_loopback();
    int ev;
    logic [7:0] d;
    tx_frame(0, 8'hA5);  expect_rx(0, 8'hA5, 1'b0, 1'b0, "loop_a5", ev);
    tx_frame(1, 8'h3C);  expect_rx(1, 8'h3C, 1'b0, 1'b0, "loop_8e1", ev);
    tx_frame(2, 8'h55);  expect_rx(2, 8'h55, 1'b0, 1'b0, "loop_7o2", ev);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        d = 8'($urandom_range(0, 255));
        tx_frame(i, d);
        expect_rx(i, d, 1'b0, 1'b0, "loop_rand", ev);
      end
    end
  endtask

  task automatic test_parity_err();
    int st, ev;
    logic [7:0] d;
    bit flip;
    drive_frame(1, 8'h03, 1'b1, 1'b1, st);  expect_rx(1, 8'h03, 1'b1, 1'b0, "perr_03", ev);
    drive_frame(1, 8'h04, 1'b0, 1'b1, st);  expect_rx(1, 8'h04, 1'b0, 1'b0, "perr_clear", ev);
    for (int r = 0; r < 6; r++) begin
      d = 8'($urandom_range(0, 255));
      flip = 1'($urandom_range(0, 1));
      drive_frame(1 + (r % 2), d, flip, 1'b1, st);
      expect_rx(1 + (r % 2), d, flip, 1'b0, "perr_rand", ev);
    end
  endtask

  task automatic test_latency();
    int st, ev, lat, expd;
    drive_frame(0, 8'h5A, 1'b0, 1'b1, st);
    expect_rx(0, 8'h5A, 1'b0, 1'b0, "latency", ev);
    lat = ev - st;
    expd = 3 + CPB / 2 + (DB[0] + ((PAR[0] != 0) ? 1 : 0) + 1) * CPB;
    checks++;
    if (lat < expd - 1 || lat > expd + 1) begin
      errors++;
      $display("FAIL rx_latency: got %0d cycles, required %0d +/-1", lat, expd);
    end
  endtask

  task automatic test_break_and_glitch();
    int st, ev, b0;
    logic pe0, fe0;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    drive_frame(0, d, 1'b0, 1'b0, st);
    repeat (40 * CPB) @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    expect_rx(0, d, 1'b0, 1'b1, "break", ev);
    b0 = busy_cnt[0];
    pe0 = rx_pe_w[0];
    fe0 = rx_fe_w[0];
    rx_drv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (busy_cnt[0] - b0 < 1 || busy_cnt[0] - b0 >= CPB) begin
      errors++;
      $display("FAIL glitch_busy: busy high %0d cycles, required between 1 and %0d", busy_cnt[0] - b0, CPB - 1);
    end
    checks++;
    if (rxlog.size() != 0) begin
      errors++;
      $display("FAIL glitch_valid: %0d frames received, required 0", rxlog.size());
    end
    checks++;
    if (rx_pe_w[0] !== pe0 || rx_fe_w[0] !== fe0 || rx_busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_flags: pe=%b fe=%b busy=%b, required %b %b 0", rx_pe_w[0], rx_fe_w[0], rx_busy_w[0], pe0, fe0);
    end
    rxlog.delete();
    drive_frame(0, 8'h3C, 1'b0, 1'b1, st);
    expect_rx(0, 8'h3C, 1'b0, 1'b0, "after_break", ev);
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[3];
    int acc[3];
    int n, guard, spacing;
    q[0] = 8'h11; q[1] = 8'h22; q[2] = 8'h33;
    loop[0] = 1'b1;
    rxlog.delete();
    wait_ready(0);
    spacing = frame_cycles(0) + 1;
    tx_data_r[0] = q[0];
    tx_valid_r[0] = 1'b1;
    n = 0;
    guard = 0;
    while (n < 3 && guard < 3 * spacing + 20) begin
      if (tx_ready_w[0] === 1'b1) begin
        acc[n] = cyc + 1;
        if (n > 0) begin
          checks++;
          if (tx_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle_gap: tx=%b in idle cycle before frame %0d, required 1", tx_w[0], n);
          end
        end
        n++;
        @(negedge clk);
        if (n < 3) tx_data_r[0] = q[n];
        else tx_valid_r[0] = 1'b0;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    tx_valid_r[0] = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_accepts: %0d accepts, required 3", n);
    end
    for (int k = 1; k < n; k++) begin
      checks++;
      if (acc[k] - acc[k-1] != spacing) begin
        errors++;
        $display("FAIL b2b_spacing: accept %0d came %0d cycles after previous, required %0d", k, acc[k] - acc[k-1], spacing);
      end
    end
    repeat (spacing + 10) @(negedge clk);
    checks++;
    if (rxlog.size() != 3) begin
      errors++;
      $display("FAIL b2b_rx_count: %0d frames received, required 3", rxlog.size());
    end
    for (int k = 0; k < rxlog.size() && k < 3; k++) begin
      checks++;
      if (rxlog[k].d !== q[k] || rxlog[k].pe !== 1'b0 || rxlog[k].fe !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rx_frame %0d: data=%02h pe=%b fe=%b, required %02h 0 0", k, rxlog[k].d, rxlog[k].pe, rxlog[k].fe, q[k]);
      end
    end
    rxlog.delete();
  endtask

  task automatic test_reset_midframe();
    int lows;
    loop[0] = 1'b1;
    rxlog.delete();
    wait_ready(0);
    tx_data_r[0] = 8'($urandom_range(0, 255));
    tx_valid_r[0] = 1'b1;
    @(negedge clk);
    tx_valid_r[0] = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    tx_valid_r[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b1 || tx_ready_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_tx: tx=%b ready=%b after reset edge, required 1/1", tx_w[0], tx_ready_w[0]);
    end
    checks++;
    if (rx_busy_w[0] !== 1'b0 || rx_valid_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_rx: busy=%b valid=%b after reset edge, required 0/0", rx_busy_w[0], rx_valid_w[0]);
    end
    rst = 1'b0;
    tx_valid_r[0] = 1'b0;
    lows = 0;
    repeat (2 * frame_cycles(0)) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL midreset_silence: tx low for %0d cycles after reset, required 0", lows);
    end
    checks++;
    if (rxlog.size() != 0) begin
      errors++;
      $display("FAIL midreset_rx_valid: %0d frames received after reset, required 0", rxlog.size());
    end
    rxlog.delete();
  endtask

  initial begin
    tx_data_r[0] = '0; tx_data_r[1] = '0; tx_data_r[2] = '0;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_parity_err();
    test_latency();
    test_break_and_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
